// File: rtl/invert_pipe.sv
// Registered invert/negate/mask unit with a 2-entry valid/ready output queue.
// The head entry drives the outputs directly from registers.
module invert_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic [1:0]       mode_i,
   input  logic [WIDTH-1:0] mask_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o,
   output logic             out_ovf_o,
   output logic             out_zero_o,
   output logic [CNT_W-1:0] ops_cnt_o
);

   localparam int EW = WIDTH + 2;
   localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};

   // Entry layout: {F, OVF, ZERO}
   function automatic logic [EW-1:0] compute(input logic [WIDTH-1:0] a,
                                             input logic [1:0]       mode,
                                             input logic [WIDTH-1:0] mask);
      logic [WIDTH-1:0] f;
      logic             ovf;
      f   = a;
      ovf = 1'b0;
      case (mode)
         2'b00: f = a;
         2'b01: f = ~a;
         2'b10: begin
            f   = ~a + ONE_W;
            ovf = (a == MSB_ONLY);
         end
         2'b11: f = a ^ mask;
         default: f = a;
      endcase
      return {f, ovf, (f == {WIDTH{1'b0}})};
   endfunction

   logic [EW-1:0]    head_q, head_d;
   logic [EW-1:0]    tail_q, tail_d;
   logic [1:0]       count_q, count_d;
   logic [CNT_W-1:0] ops_q, ops_d;
   logic [EW-1:0]    new_s;
   logic             push_s;
   logic             pop_s;

   assign in_ready_o  = (count_q != 2'd2);
   assign out_valid_o = (count_q != 2'd0);
   assign out_data_o  = head_q[EW-1:2];
   assign out_ovf_o   = head_q[1];
   assign out_zero_o  = head_q[0];
   assign ops_cnt_o   = ops_q;

   assign push_s = in_valid_i & in_ready_o;
   assign pop_s  = out_valid_o & out_ready_i;
   assign new_s  = compute(in_data_i, mode_i, mask_i);

   // Queue next-state; a pop that empties the queue leaves the head as-is.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      ops_d   = ops_q;
      if (pop_s) begin
         ops_d = ops_q + ONE_C;
      end else begin
         ops_d = ops_q;
      end
      case ({push_s, pop_s})
         2'b10: begin
            if (count_q == 2'd0) begin
               head_d = new_s;
            end else begin
               tail_d = new_s;
            end
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            if (count_q == 2'd2) begin
               head_d = tail_q;
            end else begin
               head_d = head_q;
            end
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            head_d  = new_s;
            count_d = count_q;
         end
         default: begin
            count_d = count_q;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q  <= {EW{1'b0}};
         tail_q  <= {EW{1'b0}};
         count_q <= 2'd0;
         ops_q   <= {CNT_W{1'b0}};
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ops_q   <= ops_d;
      end
   end

endmodule
